// File: rtl/fpga_toolbox_pkg.sv
// Shared sizing helpers for the chunked adder/subtractor family: how a WIDTH-bit
// operand is cut into ALU-sized chunks across a LATENCY-stage pipeline.
package fpga_toolbox_pkg;

  function automatic int unsigned alu_width(input int unsigned width,
                                            input int unsigned latency);
    return (width + latency - 1) / latency;
  endfunction

  function automatic int unsigned chunk_count(input int unsigned width,
                                              input int unsigned latency);
    return (width + alu_width(width, latency) - 1) / alu_width(width, latency);
  endfunction

  function automatic int unsigned last_chunk_width(input int unsigned width,
                                                   input int unsigned latency);
    return width - (chunk_count(width, latency) - 1) * alu_width(width, latency);
  endfunction

endpackage

// File: rtl/subtractor_pipelined_pkg.sv
// Per-chunk placement helpers for subtractor_pipelined, built on the shared
// fpga_toolbox_pkg sizing functions.
package subtractor_pipelined_pkg;
  import fpga_toolbox_pkg::*;

  function automatic int unsigned chunk_lsb(input int unsigned k,
                                            input int unsigned width,
                                            input int unsigned latency);
    return k * alu_width(width, latency);
  endfunction

  function automatic int unsigned chunk_width(input int unsigned k,
                                              input int unsigned width,
                                              input int unsigned latency);
    return (k == chunk_count(width, latency) - 1) ? last_chunk_width(width, latency)
                                                  : alu_width(width, latency);
  endfunction

endpackage

// File: rtl/subtractor_pipelined_if.sv
// Operand/result bus of subtractor_pipelined. The borrow signal exists only when
// SUBTRACTOR_PIPELINED_BORROW_EN is defined.
interface subtractor_pipelined_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] i;
  logic             out_valid;
  logic [WIDTH-1:0] q;
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
  logic             borrow;
`endif

  modport master (
    output in_valid,
    output d,
    output i,
    input  out_valid,
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
    input  borrow,
`endif
    input  q
  );

  modport slave (
    input  in_valid,
    input  d,
    input  i,
    output out_valid,
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
    output borrow,
`endif
    output q
  );
endinterface

// File: rtl/subtractor_chunk.sv
// One pipeline stage of the chunked subtractor: registered CW-bit difference
// a - b - borrow_in, plus a registered borrow-out when BORROW_OUT_EN is set.
module subtractor_chunk #(
  parameter int unsigned CW            = 1,
  parameter bit          BORROW_OUT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          borrow_in,
  output logic [CW-1:0] diff,
  output logic          borrow_out
);

  if (BORROW_OUT_EN) begin : g_bo
    logic [CW:0] full;

    // Sign bit of the (CW+1)-bit difference is the borrow.
    always_comb full = {1'b0, a} - {1'b0, b} - (CW+1)'(borrow_in);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        diff       <= '0;
        borrow_out <= 1'b0;
      end else if (ce) begin
        diff       <= full[CW-1:0];
        borrow_out <= full[CW];
      end
    end
  end else begin : g_nbo
    always_ff @(posedge clk) begin
      if (!rst_n)  diff <= '0;
      else if (ce) diff <= a - b - CW'(borrow_in);
    end

    assign borrow_out = 1'b0;
  end

endmodule

// File: rtl/subtractor_pipelined.sv
// Pipelined WIDTH-bit subtractor q = d - i, one chunk resolved per stage.
// Optional borrow output: define SUBTRACTOR_PIPELINED_BORROW_EN.
module subtractor_pipelined
  import fpga_toolbox_pkg::*;
  import subtractor_pipelined_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  subtractor_pipelined_if.slave bus
);

  localparam int unsigned CC  = chunk_count(WIDTH, LATENCY);
  localparam int unsigned PAD = LATENCY - CC;

  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0]   q_core;
  logic [CC-1:0]      bchain;
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
  logic               last_bout;
`else
  logic               last_bout_unused;
`endif

  assign bchain[0] = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (ce) begin
      vld[0] <= bus.in_valid;
      for (int unsigned s = 1; s < LATENCY; s++) vld[s] <= vld[s-1];
    end
  end

  assign bus.out_valid = vld[LATENCY-1];

  // Chunk k sees operands delayed k stages and its result is delayed CC-1-k
  // stages, so every chunk of q_core belongs to the same operand pair.
  for (genvar k = 0; k < CC; k++) begin : g_chunk
    localparam int unsigned LO = chunk_lsb(k, WIDTH, LATENCY);
    localparam int unsigned CW = chunk_width(k, WIDTH, LATENCY);

    logic [CW-1:0] a_op;
    logic [CW-1:0] b_op;
    logic [CW-1:0] r_op;

    if (k == 0) begin : g_direct
      assign a_op = bus.d[LO +: CW];
      assign b_op = bus.i[LO +: CW];
    end else begin : g_skew
      localparam int unsigned SD = k;
      logic [CW-1:0] a_sk [SD];
      logic [CW-1:0] b_sk [SD];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned j = 0; j < SD; j++) begin
            a_sk[j] <= '0;
            b_sk[j] <= '0;
          end
        end else if (ce) begin
          a_sk[0] <= bus.d[LO +: CW];
          b_sk[0] <= bus.i[LO +: CW];
          for (int unsigned j = 1; j < SD; j++) begin
            a_sk[j] <= a_sk[j-1];
            b_sk[j] <= b_sk[j-1];
          end
        end
      end

      assign a_op = a_sk[SD-1];
      assign b_op = b_sk[SD-1];
    end

    if (k < CC - 1) begin : g_mid
      subtractor_chunk #(.CW(CW), .BORROW_OUT_EN(1'b1)) u_chunk (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .a          (a_op),
        .b          (b_op),
        .borrow_in  (bchain[k]),
        .diff       (r_op),
        .borrow_out (bchain[k+1])
      );
    end else begin : g_last
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
      subtractor_chunk #(.CW(CW), .BORROW_OUT_EN(1'b1)) u_chunk (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .a          (a_op),
        .b          (b_op),
        .borrow_in  (bchain[k]),
        .diff       (r_op),
        .borrow_out (last_bout)
      );
`else
      subtractor_chunk #(.CW(CW), .BORROW_OUT_EN(1'b0)) u_chunk (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .a          (a_op),
        .b          (b_op),
        .borrow_in  (bchain[k]),
        .diff       (r_op),
        .borrow_out (last_bout_unused)
      );
`endif
    end

    if (k == CC - 1) begin : g_nodsk
      assign q_core[LO +: CW] = r_op;
    end else begin : g_dsk
      localparam int unsigned DD = CC - 1 - k;
      logic [CW-1:0] r_dsk [DD];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned j = 0; j < DD; j++) r_dsk[j] <= '0;
        end else if (ce) begin
          r_dsk[0] <= r_op;
          for (int unsigned j = 1; j < DD; j++) r_dsk[j] <= r_dsk[j-1];
        end
      end

      assign q_core[LO +: CW] = r_dsk[DD-1];
    end
  end

  // Plain delay stages make up the difference when there are fewer chunks than stages.
  if (PAD == 0) begin : g_nopad
    assign bus.q = q_core;
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
    assign bus.borrow = last_bout;
`endif
  end else begin : g_pad
    logic [WIDTH-1:0] q_dly [PAD];
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
    logic [PAD-1:0]   b_dly;
`endif

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int unsigned j = 0; j < PAD; j++) q_dly[j] <= '0;
      end else if (ce) begin
        q_dly[0] <= q_core;
        for (int unsigned j = 1; j < PAD; j++) q_dly[j] <= q_dly[j-1];
      end
    end

    assign bus.q = q_dly[PAD-1];

`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        b_dly <= '0;
      end else if (ce) begin
        b_dly[0] <= last_bout;
        for (int unsigned j = 1; j < PAD; j++) b_dly[j] <= b_dly[j-1];
      end
    end

    assign bus.borrow = b_dly[PAD-1];
`endif
  end

endmodule

// File: tb/tb_subtractor_pipelined.sv
// Scoreboard bench for subtractor_pipelined: directed cases on an 8/4 instance,
// random streams on 7/3 and 8/1 instances; borrow checked when SUBTRACTOR_PIPELINED_BORROW_EN is set.
module tb_subtractor_pipelined;

  typedef struct packed {
    logic [7:0]  q;
    logic        b;
    logic [31:0] due;
  } sb_t;

  typedef enum logic [1:0] {M_RST, M_HOLD, M_ADV} mode_t;

  int    checks   = 0;
  int    failures = 0;
  int    lat_l [3] = '{4, 3, 1};
  int    w_l   [3] = '{8, 7, 8};
  string nm    [3] = '{"a", "b", "c"};

  sb_t        sbq [3][$];
  int         cnt     [3];
  mode_t      mode    [3];
  logic       prev_ov [3];
  logic [7:0] prev_q  [3];
  logic       prev_b  [3];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, ce_a, ce_b, ce_c;
  logic bv_a, bv_b, bv_c;

  subtractor_pipelined_if #(.WIDTH(8)) if_a ();
  subtractor_pipelined_if #(.WIDTH(7)) if_b ();
  subtractor_pipelined_if #(.WIDTH(8)) if_c ();

  subtractor_pipelined #(.WIDTH(8), .LATENCY(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .ce(ce_a), .bus(if_a));
  subtractor_pipelined #(.WIDTH(7), .LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_b), .ce(ce_b), .bus(if_b));
  subtractor_pipelined #(.WIDTH(8), .LATENCY(1)) dut_c (
    .clk(clk), .rst_n(rst_c), .ce(ce_c), .bus(if_c));

`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
  assign bv_a = if_a.borrow;
  assign bv_b = if_b.borrow;
  assign bv_c = if_c.borrow;
`else
  assign bv_a = 1'b0;
  assign bv_b = 1'b0;
  assign bv_c = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: 9-bit difference of zero-extended operands, masked to lane width.
  task automatic on_edge(input int ln, input logic rn, input logic en, input logic iv,
                         input logic [7:0] dv, input logic [7:0] sv);
    logic [8:0] t;
    sb_t        e;
    if (!rn) begin
      sbq[ln].delete();
      mode[ln] = M_RST;
    end else if (!en) begin
      mode[ln] = M_HOLD;
    end else begin
      mode[ln] = M_ADV;
      cnt[ln]++;
      if (iv) begin
        t     = {1'b0, dv} - {1'b0, sv};
        e.q   = t[7:0] & 8'((32'd1 << w_l[ln]) - 1);
        e.b   = (dv < sv);
        e.due = 32'(cnt[ln] + lat_l[ln] - 1);
        sbq[ln].push_back(e);
      end
    end
  endtask

  task automatic on_mon(input int ln, input logic ov, input logic [7:0] qv, input logic bv);
    logic exp_ov;
    sb_t  e;
    case (mode[ln])
      M_RST: begin
        check_eq({nm[ln], "_rst_valid"}, 32'(ov), 32'd0);
        check_eq({nm[ln], "_rst_q"}, 32'(qv), 32'd0);
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
        check_eq({nm[ln], "_rst_borrow"}, 32'(bv), 32'd0);
`endif
      end
      M_HOLD: begin
        check_eq({nm[ln], "_hold_valid"}, 32'(ov), 32'(prev_ov[ln]));
        check_eq({nm[ln], "_hold_q"}, 32'(qv), 32'(prev_q[ln]));
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
        check_eq({nm[ln], "_hold_borrow"}, 32'(bv), 32'(prev_b[ln]));
`endif
      end
      default: begin
        exp_ov = (sbq[ln].size() > 0) && (sbq[ln][0].due == 32'(cnt[ln]));
        check_eq({nm[ln], "_valid"}, 32'(ov), 32'(exp_ov));
        if (exp_ov) begin
          e = sbq[ln].pop_front();
          check_eq({nm[ln], "_q"}, 32'(qv), 32'(e.q));
`ifdef SUBTRACTOR_PIPELINED_BORROW_EN
          check_eq({nm[ln], "_borrow"}, 32'(bv), 32'(e.b));
`endif
        end
      end
    endcase
    prev_ov[ln] = ov;
    prev_q[ln]  = qv;
    prev_b[ln]  = bv;
  endtask

  always @(posedge clk) begin
    on_edge(0, rst_a, ce_a, if_a.in_valid, if_a.d, if_a.i);
    on_edge(1, rst_b, ce_b, if_b.in_valid, {1'b0, if_b.d}, {1'b0, if_b.i});
    on_edge(2, rst_c, ce_c, if_c.in_valid, if_c.d, if_c.i);
  end

  always @(negedge clk) begin
    on_mon(0, if_a.out_valid, if_a.q, bv_a);
    on_mon(1, if_b.out_valid, {1'b0, if_b.q}, bv_b);
    on_mon(2, if_c.out_valid, if_c.q, bv_c);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] dv, input logic [7:0] sv);
    if_a.in_valid = 1'b1;
    if_a.d        = dv;
    if_a.i        = sv;
    step();
  endtask

  task automatic idle_a(input int n);
    if_a.in_valid = 1'b0;
    repeat (n) step();
  endtask

  int nb, nc;

  initial begin
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; mode[k] = M_RST; prev_ov[k] = 1'b0; prev_q[k] = '0; prev_b[k] = 1'b0;
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ce_a  = 1'b1; ce_b  = 1'b1; ce_c  = 1'b1;
    if_a.in_valid = 1'b0; if_a.d = '0; if_a.i = '0;
    if_b.in_valid = 1'b0; if_b.d = '0; if_b.i = '0;
    if_c.in_valid = 1'b0; if_c.d = '0; if_c.i = '0;
    repeat (2) step();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Borrow rippling across chunk boundaries, full wrap, equal operands.
    send_a(8'h10, 8'h01); idle_a(6);
    send_a(8'h00, 8'h01); send_a(8'h5A, 8'h5A); idle_a(6);
    send_a(8'h80, 8'h7F); send_a(8'h03, 8'h05); send_a(8'hFF, 8'h00); idle_a(6);

    // Freeze mid-flight; junk on the inputs while ce is low must be ignored.
    send_a(8'h37, 8'h12); send_a(8'hC4, 8'h4C);
    ce_a = 1'b0;
    for (int k = 0; k < 3; k++) send_a(8'hEE, 8'h11);
    ce_a = 1'b1;
    idle_a(6);

    // Reset with two pairs in flight, reset wins over a same-cycle valid input.
    send_a(8'h11, 8'h22); send_a(8'h33, 8'h44);
    rst_a = 1'b0;
    send_a(8'hAA, 8'h01);
    rst_a = 1'b1;
    idle_a(6);

    // Reset while ce is low still clears; first result counts from release.
    send_a(8'h55, 8'h44);
    ce_a = 1'b0; rst_a = 1'b0;
    idle_a(1);
    ce_a = 1'b1; rst_a = 1'b1;
    send_a(8'h09, 8'h03); idle_a(6);

    nb = 0; nc = 0;
    for (int c = 0; c < 6000 && (nb < 1000 || nc < 1000); c++) begin
      ce_b = ($urandom_range(0, 9) != 0);
      ce_c = ($urandom_range(0, 9) != 0);
      if_b.in_valid = (nb < 1000) && ($urandom_range(0, 7) != 0);
      if_c.in_valid = (nc < 1000) && ($urandom_range(0, 7) != 0);
      if_b.d = ($urandom_range(0, 15) == 0) ? 7'h00 : 7'($urandom_range(0, 127));
      if_b.i = ($urandom_range(0, 15) == 0) ? 7'h7F : 7'($urandom_range(0, 127));
      if_c.d = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if_c.i = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      if (ce_b && if_b.in_valid) nb++;
      if (ce_c && if_c.in_valid) nc++;
      step();
    end
    ce_b = 1'b1; ce_c = 1'b1;
    if_b.in_valid = 1'b0; if_c.in_valid = 1'b0;
    repeat (8) step();

    check_eq("b_pairs", 32'(nb), 32'd1000);
    check_eq("c_pairs", 32'(nc), 32'd1000);
    for (int k = 0; k < 3; k++) check_eq({nm[k], "_drain"}, 32'(sbq[k].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subtractor_pipelined.md
SUBTRACTOR_PIPELINED -- requirements
Module: subtractor_pipelined

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand and result width in bits, WIDTH >= 1.
REQ-002 SHALL have parameter LATENCY, default 4: cycles from input accept to result valid, 1 <= LATENCY <= WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ce  input  1  pipeline enable; low freezes all pipeline state.
REQ-006 SHALL have port in_valid  input  1  d/i carry a new operand pair.
REQ-007 SHALL have port d  input  WIDTH  minuend.
REQ-008 SHALL have port i  input  WIDTH  subtrahend.
REQ-009 SHALL have port out_valid  output  1  q is a valid result this cycle.
REQ-010 SHALL have port q  output  WIDTH  d - i modulo 2^WIDTH.
REQ-011 SHALL have port borrow  output  1  set when d < i (unsigned), qualified by out_valid; present only per REQ-024.

Function
REQ-012 SHALL split operands into chunks: ALU_WIDTH = ceil(WIDTH/LATENCY), CHUNK_COUNT = ceil(WIDTH/ALU_WIDTH), last chunk = WIDTH - (CHUNK_COUNT-1)*ALU_WIDTH bits.
REQ-013 SHALL resolve chunk k in pipeline stage k, with the registered borrow from chunk k-1 as borrow-in; chunk 0 borrow-in = 0.
REQ-014 SHALL skew-delay upper operand chunks and deskew-delay lower result chunks so that all q bits belong to the same operand pair.
REQ-015 SHALL pad with plain delay stages when CHUNK_COUNT < LATENCY so latency is exactly LATENCY enabled cycles.
REQ-016 SHALL assert out_valid exactly LATENCY cycles with ce=1 after a cycle with ce=1 and in_valid=1, with q = (d - i) mod 2^WIDTH of that pair.
REQ-017 SHALL accept one operand pair per enabled cycle (throughput 1), with no backpressure.
REQ-018 SHALL ignore d, i, in_valid while ce=0 and hold q, out_valid, borrow and all internal stages unchanged.
REQ-019 SHALL propagate invalid bubbles as out_valid=0; q content during out_valid=0 is don't-care but deterministic.
REQ-020 SHALL handle d == i -> q=0, borrow=0; d=0,i=2^WIDTH-1 -> q=1, borrow=1; wrap-around never saturates.

Reset
REQ-021 SHALL clear on rst_n=0 at a clock edge, regardless of ce: every valid bit, every borrow-chain register, q=0, out_valid=0, borrow=0.
REQ-022 SHALL discard all in-flight operands when reset is asserted mid-operation; first valid result after release follows REQ-016 counting from release.
REQ-023 SHALL give rst_n priority over ce and in_valid in the same cycle.

Configuration
REQ-024 SHALL, when macro SUBTRACTOR_PIPELINED_BORROW_EN is defined, add the borrow port driven from the final chunk's borrow-out, aligned with q; when undefined, borrow port and final-chunk borrow logic are absent and the design is otherwise identical.

Structure
REQ-025 SHALL take ALU_WIDTH/CHUNK_COUNT/last-chunk-size calculation functions from shared package fpga_toolbox_pkg, also used by adder variants.
REQ-026 SHALL instantiate sub-module subtractor_chunk (parameter CW: registered CW-bit difference plus registered borrow-out, with ce and rst_n) once per chunk.

Verification
REQ-027 SHALL cover WIDTH=8, LATENCY=4, d=0x10, i=0x01 -> after 4 cycles out_valid=1, q=0x0F, borrow=0 (borrow ripples through chunks).
REQ-028 SHALL cover WIDTH=8, LATENCY=4, d=0x00, i=0x01 -> q=0xFF, borrow=1; d=0x5A, i=0x5A -> q=0x00, borrow=0.
REQ-029 SHALL cover back-to-back in_valid pairs (0x80-0x7F, 0x03-0x05, 0xFF-0x00) -> consecutive results 0x01, 0xFE (borrow=1), 0xFF on 3 consecutive cycles.
REQ-030 SHALL cover ce=0 for 3 cycles mid-flight -> outputs frozen, result emerges 3 cycles later with correct value.
REQ-031 SHALL cover rst_n=0 for 1 cycle with 2 pairs in flight -> out_valid stays 0 for LATENCY cycles, q=0.
REQ-032 SHALL cover WIDTH=7, LATENCY=3 (uneven chunks 3/3/1) and WIDTH=8, LATENCY=1: random stream vs. reference model, 1000 pairs, zero mismatches.
